// File: rtl/approx_shift_add_core.sv
`default_nettype none
// ============================================================================
// Module   : approx_shift_add_core
// Brief    : Serial shift-add multiplier that skips the low acc_k multiplier bits.
// Revision : 1.0 - initial release
// ============================================================================
module approx_shift_add_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [63:0]  a,
    input  logic [5:0]   acc_k,
    output logic [5:0]   sel,
    input  logic         y,
    output logic         busy,
    output logic         done,
    output logic [127:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_IDX = 6'd63;

    state_t         r_state;
    state_t         w_next;
    logic [63:0]    r_a;
    logic [5:0]     r_idx;
    logic [127:0]   r_acc;
    logic [127:0]   r_product;
    logic [127:0]   w_addend;
    logic [127:0]   w_acc_next;

    always_comb begin
        w_addend   = {64'd0, r_a} << r_idx;
        w_acc_next = y ? (r_acc + w_addend) : r_acc;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (r_idx == c_LAST_IDX) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The product is loaded on the RUN->DONE edge so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= 64'd0;
            r_idx     <= 6'd0;
            r_acc     <= 128'd0;
            r_product <= 128'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_idx <= acc_k;
                        r_acc <= 128'd0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_idx == c_LAST_IDX) begin
                        r_product <= w_acc_next;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sel     = r_idx;
    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_approx_shift_add_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_shift_add_core
// Brief    : Scoreboard bench for approx_shift_add_core with a modelled 64:1 mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_shift_add_core;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [63:0]  a;
    logic [5:0]   acc_k;
    logic [5:0]   sel;
    logic         y;
    logic         busy;
    logic         done;
    logic [127:0] product;
    logic [63:0]  mux_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] prod;
        int           len;
        logic [5:0]   sel0;
    } exp_t;

    exp_t sb[$];
    int   busy_cnt = 0;

    approx_shift_add_core u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .acc_k   (acc_k),
        .sel     (sel),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always_comb y = mux_b[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: tracks RUN length and first sel, pops the scoreboard on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            busy_cnt = 0;
        end else begin
            if (busy) begin
                if (busy_cnt == 0 && sb.size() > 0)
                    check_eq("first_sel", {122'd0, sel}, {122'd0, sb[0].sel0});
                busy_cnt++;
            end
            if (done) begin
                check_eq("done_busy_excl", {127'd0, busy}, 128'd0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", {127'd0, done}, 128'd0);
                end else begin
                    check_eq("product", product, sb[0].prod);
                    check_eq("run_len", 128'(busy_cnt), 128'(sb[0].len));
                    void'(sb.pop_front());
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {product, sel, busy, done}, 136'd0);
    endtask

    task automatic run_op(input logic [63:0] b, input logic [63:0] av, input logic [5:0] k,
                          input int restart_cyc, input int abort_cyc);
        exp_t        e;
        logic [63:0] ones;
        logic [63:0] bm;
        int          cyc;
        bit          got;
        ones   = {64{1'b1}};
        bm     = b & (ones << k);
        e.prod = {64'd0, av} * {64'd0, bm};
        e.len  = 64 - int'(k);
        e.sel0 = k;
        @(negedge clk);
        mux_b = b; a = av; acc_k = k; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; a = ~av; acc_k = k ^ 6'h2A;
        cyc = 1; got = 0;
        while (cyc < 200) begin
            if (done) begin
                got = 1;
                break;
            end
            if (cyc == abort_cyc) begin
                rst_n = 1'b0; start = 1'b1;
                @(negedge clk);
                check_reset_outputs("abort_outputs");
                @(negedge clk);
                check_reset_outputs("abort_hold");
                rst_n = 1'b1; start = 1'b0;
                @(negedge clk);
                check_eq("start_dropped", {127'd0, busy}, 128'd0);
                return;
            end
            start = (cyc == restart_cyc);
            if (start) a = {$urandom, $urandom};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq("done_seen", {127'd0, got}, 128'd1);
        if (got) begin
            @(negedge clk);
            check_eq("product_hold", product, e.prod);
            check_eq("idle_after", {126'd0, busy, done}, 128'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; acc_k = '0; mux_b = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(64'h5, 64'd3, 6'd0, -1, -1);
        run_op(64'h5, 64'd3, 6'd1, -1, -1);
        run_op({64{1'b1}}, {64{1'b1}}, 6'd0, -1, -1);
        run_op({64{1'b1}}, {64{1'b1}}, 6'd63, -1, -1);
        run_op(64'hDEAD_BEEF_0123_4567, 64'h1357_9BDF_2468_ACE0, 6'd4, 10, -1);
        for (int i = 0; i < 4; i++)
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 6'($urandom_range(0, 63)), -1, -1);
        run_op({64{1'b1}}, 64'hFFFF_0000_FFFF_0000, 6'd0, -1, 20);
        run_op(64'h5, 64'd3, 6'd0, -1, -1);

        check_eq("sb_empty", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/approx_shift_add_core.md
APPROX_SHIFT_ADD_CORE -- requirements
Module: approx_shift_add_core

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-003 SHALL: start  input  1  request a new multiply; sampled only in IDLE.
REQ-004 SHALL: a  input  64  multiplicand; captured on accepted start.
REQ-005 SHALL: acc_k  input  6  accuracy control = count of low multiplier bits skipped; captured on accepted start.
REQ-006 SHALL: sel  output  6  bit index driven to the downstream 64:1 multiplier-bit mux.
REQ-007 SHALL: y  input  1  selected multiplier bit returned by that mux, combinational from sel within the same cycle.
REQ-008 SHALL: busy  output  1  high while in RUN.
REQ-009 SHALL: done  output  1  one-cycle pulse when product is final.
REQ-010 SHALL: product  output  128  approximate product, registered.

Function
REQ-011 SHALL: FSM states IDLE, RUN, DONE; encoding free.
REQ-012 SHALL: IDLE: if start=1, latch a -> a_r, acc_k -> idx, clear accumulator to 0, go RUN next cycle; otherwise stay in IDLE.
REQ-013 SHALL: sel equal registered idx at all times (no combinational path from start/a/acc_k to sel).
REQ-014 SHALL: RUN, each cycle: if y=1, accumulator <= accumulator + (zero-extended a_r << idx), computed at 128 bits with no overflow possible.
REQ-015 SHALL: RUN: if idx=63 go DONE, else idx <= idx+1; idx never wraps.
REQ-016 SHALL: RUN length exactly 64-acc_k cycles (acc_k=0 -> 64, acc_k=63 -> 1).
REQ-017 SHALL: DONE: product <= accumulator value including the final RUN addition; done=1 for exactly this one cycle; unconditional return to IDLE.
REQ-018 SHALL: product hold its value from DONE until the next DONE or reset; not updated during RUN.
REQ-019 SHALL: start while RUN or DONE be ignored; no restart, no queuing.
REQ-020 SHALL: acc_k and a changing during RUN have no effect (latched copies used).
REQ-021 SHALL: multiplier data held by the mux stay stable for the whole RUN; the core does not re-check it.
REQ-022 SHALL: result = a * (B with bits [acc_k-1:0] forced to 0), where B is the 64-bit mux data; error bound < a * 2^acc_k.
REQ-023 SHALL: busy=1 exactly in RUN; done and busy never both 1.

Reset
REQ-024 SHALL: rst_n=0 at a clock edge force IDLE, idx=0, sel=0, accumulator=0, product=0, busy=0, done=0, taking priority over start and every state transition.
REQ-025 SHALL: reset asserted mid-RUN abort the operation with no done pulse; the next start after rst_n=1 is processed normally.
REQ-026 SHALL: start asserted in the same cycle as rst_n=0 be dropped.

Verification
REQ-027 SHALL: mux data B=0x5, a=3, acc_k=0, start pulse -> busy 64 cycles, then done pulse, product=15.
REQ-028 SHALL: B=0x5, a=3, acc_k=1 -> busy 63 cycles, product=12 (bit0 skipped); first sel after start=1.
REQ-029 SHALL: B=all ones, a=all ones, acc_k=0 -> product=0xFFFFFFFFFFFFFFFE0000000000000001.
REQ-030 SHALL: B=all ones, a=all ones, acc_k=63 -> busy 1 cycle with sel=63, product=(2^64-1)<<63.
REQ-031 SHALL: start re-pulsed at RUN cycle 10 with different a -> ignored; product as for the original operands.
REQ-032 SHALL: rst_n=0 at RUN cycle 20 -> no done pulse, all outputs 0 next cycle; a subsequent start with B=0x5, a=3, acc_k=0 -> product=15.
